// File: rtl/mips_pipeline_ifid_pkg.sv
// rtl/mips_pipeline_ifid_pkg.sv - shared IF/ID entry type, NOP constant and opFunc field positions
package mips_pipeline_ifid_pkg;

    localparam int ADDR_W   = 32;
    localparam int INSTR_W  = 32;
    localparam int OPFUNC_W = 12;
    localparam int CNT_W    = 16;

    // opFunc = {opcode, funct}; reused by the opFunc control and categorizer blocks
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifid_entry_t;

    localparam ifid_entry_t IFID_NOP = '0;

endpackage

// File: rtl/mips_pipeline_ifid_slot.sv
// rtl/mips_pipeline_ifid_slot.sv - one {valid, pc, instr} pipeline entry with load and clear
module mips_pipeline_ifid_slot #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic               d_valid,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    // clear kills the entry but keeps pc; instr is zeroed so a dead entry reads as NOP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= '0;
        end else if (load) begin
            valid <= d_valid;
            pc    <= d_pc;
            instr <= d_instr;
        end
    end

endmodule

// File: rtl/mips_pipeline_ifid_latch.sv
// rtl/mips_pipeline_ifid_latch.sv - IF/ID register with skid slot, stall/flush and bubble counter
module mips_pipeline_ifid_latch
    import mips_pipeline_ifid_pkg::*;
#(
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_INSTR_W  = INSTR_W,
    parameter int P_OPFUNC_W = OPFUNC_W,
    parameter int P_CNT_W    = CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifValid,
    output logic                  ifReady,
    input  logic [P_ADDR_W-1:0]   ifPc,
    input  logic [P_INSTR_W-1:0]  ifInstr,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  idValid,
    output logic [P_ADDR_W-1:0]   idPc,
    output logic [P_ADDR_W-1:0]   idPcPlus4,
    output logic [P_INSTR_W-1:0]  idInstr,
    output logic [P_OPFUNC_W-1:0] idOpFunc,
    output logic [P_CNT_W-1:0]    bubbleCount
);

    logic                 m_valid, s_valid;
    logic [P_ADDR_W-1:0]  m_pc, s_pc;
    logic [P_INSTR_W-1:0] m_instr, s_instr;
    logic                 accept;
    logic                 m_load, s_load, s_clear;
    logic                 m_d_valid;
    logic [P_ADDR_W-1:0]  m_d_pc;
    logic [P_INSTR_W-1:0] m_d_instr;

    assign ifReady = !s_valid;
    assign accept  = ifValid && ifReady;

    // flush > stall > advance; while S is full ifReady is low, so advance drains S first
    assign m_load  = !flush && !stall;
    assign s_load  = !flush && stall && accept;
    assign s_clear = flush || (!stall && s_valid);

    always_comb begin
        m_d_valid = ifValid;
        m_d_pc    = ifPc;
        m_d_instr = ifValid ? ifInstr : '0;
        if (s_valid) begin
            m_d_valid = 1'b1;
            m_d_pc    = s_pc;
            m_d_instr = s_instr;
        end
    end

    mips_pipeline_ifid_slot #(.ADDR_W(P_ADDR_W), .INSTR_W(P_INSTR_W)) u_main (
        .clock   (clock),
        .reset   (reset),
        .load    (m_load),
        .clear   (flush),
        .d_valid (m_d_valid),
        .d_pc    (m_d_pc),
        .d_instr (m_d_instr),
        .valid   (m_valid),
        .pc      (m_pc),
        .instr   (m_instr)
    );

    mips_pipeline_ifid_slot #(.ADDR_W(P_ADDR_W), .INSTR_W(P_INSTR_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load    (s_load),
        .clear   (s_clear),
        .d_valid (1'b1),
        .d_pc    (ifPc),
        .d_instr (ifInstr),
        .valid   (s_valid),
        .pc      (s_pc),
        .instr   (s_instr)
    );

    assign idValid   = m_valid;
    assign idPc      = m_pc;
    assign idPcPlus4 = m_pc + P_ADDR_W'(4);
    assign idInstr   = m_valid ? m_instr : '0;
    assign idOpFunc  = {idInstr[OPCODE_HI:OPCODE_LO], idInstr[FUNCT_HI:FUNCT_LO]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubbleCount <= '0;
        end else if (!m_valid && (bubbleCount != {P_CNT_W{1'b1}})) begin
            bubbleCount <= bubbleCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_pipeline_ifid_latch.sv
// tb/tb_mips_pipeline_ifid_latch.sv - randomized and directed bench for the IF/ID latch
module tb_mips_pipeline_ifid_latch;
    import mips_pipeline_ifid_pkg::*;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               ifValid = 1'b0;
    logic               ifReady;
    logic [ADDR_W-1:0]  ifPc = '0;
    logic [INSTR_W-1:0] ifInstr = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic               idValid;
    logic [ADDR_W-1:0]  idPc;
    logic [ADDR_W-1:0]  idPcPlus4;
    logic [INSTR_W-1:0] idInstr;
    logic [OPFUNC_W-1:0] idOpFunc;
    logic [CNT_W-1:0]   bubbleCount;

    int checks = 0;
    int errors = 0;

    // reference: decode entry, a FIFO of held-back fetches, and a plain bubble tally
    bit                 mv;
    logic [ADDR_W-1:0]  mpc;
    logic [INSTR_W-1:0] minstr;
    ifid_entry_t        skid[$];
    int                 bcnt;
    localparam int BMAX = (1 << CNT_W) - 1;

    mips_pipeline_ifid_latch dut (
        .clock       (clock),
        .reset       (reset),
        .ifValid     (ifValid),
        .ifReady     (ifReady),
        .ifPc        (ifPc),
        .ifInstr     (ifInstr),
        .stall       (stall),
        .flush       (flush),
        .idValid     (idValid),
        .idPc        (idPc),
        .idPcPlus4   (idPcPlus4),
        .idInstr     (idInstr),
        .idOpFunc    (idOpFunc),
        .bubbleCount (bubbleCount)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mv = 0; mpc = '0; minstr = '0; bcnt = 0;
        skid.delete();
    endtask

    task automatic model_edge();
        ifid_entry_t e;
        bit ready;
        ready = (skid.size() == 0);
        if (!mv && bcnt < BMAX) bcnt++;
        if (flush) begin
            mv = 0; minstr = '0;
            skid.delete();
        end else if (stall) begin
            if (ifValid && ready) begin
                e.valid = 1'b1; e.pc = ifPc; e.instr = ifInstr;
                skid.push_back(e);
            end
        end else if (!ready) begin
            e = skid.pop_front();
            mv = 1; mpc = e.pc; minstr = e.instr;
        end else begin
            mv = ifValid; mpc = ifPc; minstr = ifValid ? ifInstr : '0;
        end
    endtask

    function automatic logic [OPFUNC_W-1:0] exp_opfunc(input logic [INSTR_W-1:0] w);
        return {w[31:26], w[5:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                         input bit st, input bit fl);
        ifValid = v; ifPc = pc; ifInstr = ins; stall = st; flush = fl;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0);
        reset = 1'b1;
        model_reset();
        #12;
        @(negedge clock);
        reset = 1'b0;
        #4;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 32'h100, 32'hAAAA_0001, 0, 0);
        tick();
        drive(1, 32'h104, 32'hAAAA_0002, 1, 0);
        tick();
        checks++;
        if (ifReady !== 1'b0) begin
            errors++; $display("FAIL reset_setup_skid_full ifReady got %0b exp 0", ifReady);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (idValid !== 1'b0 || idInstr !== '0 || ifReady !== 1'b1 || bubbleCount !== '0
            || idPcPlus4 !== 32'h4 || idPc !== '0 || idOpFunc !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b instr=%h rdy=%0b bc=%0d pc4=%h pc=%h op=%h exp 0,0,1,0,4,0,0",
                     idValid, idInstr, ifReady, bubbleCount, idPcPlus4, idPc, idOpFunc);
        end
        drive(0, '0, '0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        #4;
        tick();
        checks++;
        if (idValid !== 1'b0 || ifReady !== 1'b1 || bubbleCount !== CNT_W'(bcnt)) begin
            errors++;
            $display("FAIL reset_after_release got v=%0b rdy=%0b bc=%0d exp 0,1,%0d",
                     idValid, ifReady, bubbleCount, bcnt);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(i * 4), 32'h012A_4020, 0, 0);
            tick();
            checks++;
            if (idValid !== 1'b1 || idPc !== 32'(i * 4) || idInstr !== 32'h012A_4020
                || idOpFunc !== 12'h020 || ifReady !== 1'b1 || idPcPlus4 !== 32'(i * 4 + 4)) begin
                errors++;
                $display("FAIL stream_%0d got v=%0b pc=%h instr=%h op=%h rdy=%0b exp 1,%h,012a4020,020,1",
                         i, idValid, idPc, idInstr, idOpFunc, ifReady, i * 4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 32'h10, 32'h0000_0010, 0, 0);
        tick();
        drive(1, 32'h14, 32'h0000_0014, 1, 0);
        tick();
        drive(1, 32'h18, 32'h0000_0018, 1, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (idPc !== 32'h10 || idValid !== 1'b1 || ifReady !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got pc=%h v=%0b rdy=%0b exp 10,1,0", i, idPc, idValid, ifReady);
            end
            tick();
        end
        checks++;
        if (idPc !== 32'h10 || ifReady !== 1'b0) begin
            errors++; $display("FAIL stall_hold_2 got pc=%h rdy=%0b exp 10,0", idPc, ifReady);
        end
        drive(1, 32'h18, 32'h0000_0018, 0, 0);
        tick();
        checks++;
        if (idPc !== 32'h14 || idInstr !== 32'h14 || idValid !== 1'b1 || ifReady !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got pc=%h instr=%h v=%0b rdy=%0b exp 14,14,1,1", idPc, idInstr, idValid, ifReady);
        end
        tick();
        checks++;
        if (idPc !== 32'h18 || idInstr !== 32'h18 || idValid !== 1'b1) begin
            errors++; $display("FAIL stall_next got pc=%h instr=%h v=%0b exp 18,18,1", idPc, idInstr, idValid);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1, 32'h40, 32'h1234_5678, 0, 0);
        tick();
        drive(1, 32'h44, 32'h8765_4321, 1, 0);
        tick();
        drive(1, 32'h48, 32'hDEAD_BEEF, 1, 1);
        tick();
        checks++;
        if (idValid !== 1'b0 || idInstr !== '0 || ifReady !== 1'b1 || idOpFunc !== '0) begin
            errors++;
            $display("FAIL flush_stall got v=%0b instr=%h rdy=%0b op=%h exp 0,0,1,0", idValid, idInstr, ifReady, idOpFunc);
        end
        drive(1, 32'h80, 32'h0000_0080, 0, 0);
        tick();
        checks++;
        if (idPc !== 32'h80 || idValid !== 1'b1) begin
            errors++; $display("FAIL flush_redirect got pc=%h v=%0b exp 80,1", idPc, idValid);
        end
    endtask

    task automatic test_pc_wrap();
        drive(1, 32'hFFFF_FFFC, 32'h0000_0008, 0, 0);
        tick();
        checks++;
        if (idPc !== 32'hFFFF_FFFC || idPcPlus4 !== 32'h0) begin
            errors++; $display("FAIL pc_wrap got pc=%h pc4=%h exp fffffffc,0", idPc, idPcPlus4);
        end
    endtask

    task automatic test_bubble_saturate();
        do_reset();
        drive(0, '0, '0, 0, 0);
        for (int i = 0; i < BMAX - 1; i++) tick();
        checks++;
        if (bubbleCount !== CNT_W'(BMAX - 1)) begin
            errors++; $display("FAIL bubble_pre_sat got %0d exp %0d", bubbleCount, BMAX - 1);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bubbleCount !== {CNT_W{1'b1}}) begin
            errors++; $display("FAIL bubble_sat got %0d exp %0d", bubbleCount, BMAX);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0]  fpc;
        logic [INSTR_W-1:0] fins;
        do_reset();
        fpc = 32'h1000;
        fins = $urandom;
        for (int c = 0; c < 400; c++) begin
            bit v;
            v = ($urandom_range(0, 9) < 7);
            drive(v, fpc, fins, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            if (v && skid.size() == 0 && !flush) begin
                fpc = fpc + 4;
                fins = $urandom;
            end
            tick();
            checks++;
            if (idValid !== mv) begin
                errors++; $display("FAIL rand_idValid cyc %0d got %0b exp %0b", c, idValid, mv);
            end
            checks++;
            if (idPc !== mpc || idPcPlus4 !== mpc + 32'd4) begin
                errors++; $display("FAIL rand_idPc cyc %0d got %h/%h exp %h", c, idPc, idPcPlus4, mpc);
            end
            checks++;
            if (idInstr !== (mv ? minstr : '0) || idOpFunc !== exp_opfunc(mv ? minstr : '0)) begin
                errors++; $display("FAIL rand_idInstr cyc %0d got %h/%h exp %h", c, idInstr, idOpFunc, minstr);
            end
            checks++;
            if (ifReady !== (skid.size() == 0)) begin
                errors++; $display("FAIL rand_ifReady cyc %0d got %0b exp %0b", c, ifReady, skid.size() == 0);
            end
            checks++;
            if (bubbleCount !== CNT_W'(bcnt)) begin
                errors++; $display("FAIL rand_bubbleCount cyc %0d got %0d exp %0d", c, bubbleCount, bcnt);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_stream();
        test_stall();
        test_flush_stall();
        test_pc_wrap();
        test_random();
        test_bubble_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
